fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_pc_next_sel.sv | 24 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcodes and state encoding
// for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int PC_W    = 26;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_J    = 6'b010110;
  localparam logic [5:0] OP_HALT = 6'b011000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } fetch_state_e;

  function automatic logic [5:0] opcode(
    input logic [INSTR_W-1:0] w
  );
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next fetch address: redirect, then
// direct jump, then sequential.
module pc_next_sel
  import fetch_unit_pkg::*;
(
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instrucao,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc_next
);

  always_comb begin
    pc_next = pc + PC_W'(1);
    unique case (1'b1)
      branch_taken:
        pc_next = branch_target;
      (opcode(instrucao) == OP_J):
        pc_next = instrucao[PC_W-1:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM
// address and registers the fetched word.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 26'd0,
  parameter int              ROM_DEPTH = 19
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instrucao,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  output logic               halted,
  output logic               fault
);

  localparam logic [PC_W-1:0] DEPTH =
    PC_W'(ROM_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic               vld_q, vld_d;
  logic               halt_q, fault_q;
  logic [PC_W-1:0]    pc_nxt;

  pc_next_sel u_sel (
    .pc            (pc_q),
    .instrucao     (instrucao),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_next       (pc_nxt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    vld_d   = vld_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        vld_d   = 1'b0;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d  = pc_nxt;
          vld_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_q >= DEPTH) begin
          state_d = ST_FAULT;
          vld_d   = 1'b0;
        end else begin
          ir_d    = instrucao;
          ir_pc_d = pc_q;
          vld_d   = 1'b1;
          // HALT keeps pc on the halting word
          if (opcode(instrucao) == OP_HALT)
            state_d = ST_HALT;
          else
            pc_d = pc_nxt;
        end
      end
      ST_HALT: begin
        if (!stall) vld_d = 1'b0;
      end
      ST_FAULT: begin
        vld_d = 1'b0;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
      vld_q   <= 1'b0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      vld_q   <= vld_d;
      halt_q  <= (state_d == ST_HALT);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = vld_q;
  assign halted   = halt_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a
// small ROM and an expected-word scoreboard.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [25:0] pc;
  logic [31:0] instrucao;
  logic        stall;
  logic        branch_taken;
  logic [25:0] branch_target;
  logic [31:0] ir;
  logic [25:0] ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        fault;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] rom [0:31];
  logic [57:0] sbq [$];
  logic [57:0] exp_w;
  logic        last_v;
  logic [57:0] last_w;

  fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .instrucao     (instrucao),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .halted        (halted),
    .fault         (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign instrucao = (pc < 26'd32) ? rom[pc[4:0]] : 32'd0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step(
    input logic        st,
    input logic        br,
    input logic [25:0] tgt,
    input int          exp_pc,
    input logic        exp_v,
    input logic        cap,
    input int          cap_pc
  );
    logic [57:0] w;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (cap)
      sbq.push_back({26'(cap_pc), rom[cap_pc[4:0]]});
    @(posedge clock);
    #1;
    w = {ir_pc, ir};
    if (ir_valid && (!last_v || w != last_w)) begin
      if (sbq.size() == 0) begin
        chk("sb_extra", {6'd0, w}, 64'd0);
      end else begin
        exp_w = sbq.pop_front();
        chk("sb_word", {6'd0, w}, {6'd0, exp_w});
      end
    end
    last_v = ir_valid;
    last_w = w;
    chk("sb_lat", 64'(sbq.size()), 64'd0);
    chk("pc", 64'(pc), 64'(exp_pc));
    chk("valid", 64'(ir_valid), 64'(exp_v));
    stall        = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_irpc", 64'(ir_pc), 64'd0);
    chk("rst_vld", 64'(ir_valid), 64'd0);
    chk("rst_halt", 64'(halted), 64'd0);
    chk("rst_flt", 64'(fault), 64'd0);
    sbq.delete();
    last_v = 1'b0;
    last_w = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rom[i] = {6'b000001, 26'(i * 37 + 5)};
    rom[0]  = {6'b010110, 26'd1};
    rom[18] = {6'b011000, 26'h123};
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    reset         = 1'b0;
    last_v        = 1'b0;
    last_w        = '0;
    #3;
    do_reset();

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 2, 1, 1, 1);
    step(0, 0, 0, 3, 1, 1, 2);
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 0, 3, 1, 0, 0);
      chk("stall_irpc", 64'(ir_pc), 64'd2);
    end
    for (int p = 3; p < 8; p++)
      step(0, 0, 0, p + 1, 1, 1, p);

    step(0, 1, 26'd16, 16, 0, 0, 0);
    chk("br_irpc", 64'(ir_pc), 64'd7);
    step(1, 1, 26'd17, 17, 0, 0, 0);
    step(0, 0, 0, 18, 1, 1, 17);

    step(0, 0, 0, 18, 1, 1, 18);
    chk("halt_on", 64'(halted), 64'd1);
    chk("halt_flt", 64'(fault), 64'd0);
    chk("halt_irpc", 64'(ir_pc), 64'd18);
    step(0, 1, 26'd5, 18, 0, 0, 0);
    chk("halt_hold", 64'(halted), 64'd1);
    step(0, 0, 0, 18, 0, 0, 0);

    #2;
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 26'd19, 19, 0, 0, 0);
    step(0, 0, 0, 19, 0, 0, 0);
    chk("flt_on", 64'(fault), 64'd1);
    chk("flt_halt", 64'(halted), 64'd0);
    chk("flt_irpc", 64'(ir_pc), 64'd0);
    chk("flt_ir", 64'(ir), 64'(rom[0]));
    step(0, 1, 26'd3, 19, 0, 0, 0);
    step(1, 0, 0, 19, 0, 0, 0);
    chk("flt_hold", 64'(fault), 64'd1);

    #2;
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    chk("end_q", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
